// File: rtl/bht_resolve_queue.sv
// bht_resolve_queue: in-order in-flight branch tracker, prediction to resolve.
// Macro BHT_RESOLVE_STATS_EN builds the total/miss statistics counters.
module bht_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pred_valid,
  input  logic [PC_W-1:0]         pred_pc,
  input  logic                    pred_taken,
  output logic                    pred_ready,
  input  logic                    res_valid,
  input  logic                    res_taken,
  output logic                    upd_valid,
  output logic [PC_W-1:0]         upd_pc,
  output logic                    upd_taken,
  output logic                    mispredict,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } ent_t;

  ent_t        mem [DEPTH];
  ent_t        head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        do_enq;
  logic        do_res;
  logic        miss;

  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                (wr_ptr[AW] != rd_ptr[AW]);
  assign pred_ready = !full;
  assign occupancy = wr_ptr - rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];

  assign do_enq = pred_valid && !full;
  assign do_res = res_valid && !empty;
  assign miss = do_res && (head.pred != res_taken);

  // Wrong-path fetch in the mispredict cycle must not land in the queue
  always_ff @(posedge clk) begin
    if (do_enq && !miss) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: pred_pc, pred: pred_taken};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      mispredict <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (do_res) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        upd_pc    <= head.pc;
        upd_taken <= res_taken;
      end
      if (miss) begin
        wr_ptr <= rd_ptr + PTR_ONE;
      end else if (do_enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      upd_valid  <= do_res;
      mispredict <= miss;
      if (res_valid && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef BHT_RESOLVE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      if (do_res && (total_cnt != '1)) begin
        total_cnt <= total_cnt + CNT_ONE;
      end
      if (miss && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CNT_ONE;
      end
    end
  end
`else
  assign total_cnt = '0;
  assign miss_cnt  = '0;
`endif

endmodule

// File: tb/tb_bht_resolve_queue.sv
// tb_bht_resolve_queue: randomized and directed bench for bht_resolve_queue.
// Expected values come from a queue-based model of in-flight branches.
module tb_bht_resolve_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] CMAX = 16'hFFFF;

  typedef struct {
    logic [8:0] pc;
    logic       pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pred_valid = 1'b0;
  logic [8:0]  pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic        pred_ready;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        upd_valid;
  logic [8:0]  upd_pc;
  logic        upd_taken;
  logic        mispredict;
  logic        underflow;
  logic [2:0]  occupancy;
  logic [15:0] total_cnt;
  logic [15:0] miss_cnt;

  int n_checks = 0;
  int n_fail = 0;

  ent_t        q[$];
  logic        m_uv, m_tk, m_miss, m_uf;
  logic [8:0]  m_pc;
  logic [15:0] m_tot, m_mc;

  bht_resolve_queue #(.DEPTH(DEPTH), .PC_W(9), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .mispredict(mispredict),
    .underflow(underflow), .occupancy(occupancy),
    .total_cnt(total_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef BHT_RESOLVE_STATS_EN
    return v;
`else
    return (v & 16'h0);
`endif
  endfunction

  function automatic logic [2:0] m_occ();
    return 3'(q.size());
  endfunction

  task automatic model_reset();
    q.delete();
    m_uv = 0; m_tk = 0; m_miss = 0; m_uf = 0;
    m_pc = '0; m_tot = '0; m_mc = '0;
  endtask

  task automatic apply_reset();
    pred_valid = 0;
    res_valid = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  // One clock: drive inputs, advance the model, sample at edge+1.
  task automatic cycle(input logic pv, input logic [8:0] pc,
                       input logic pt, input logic rv,
                       input logic rt);
    ent_t h;
    bit res, enq, mis;
    pred_valid = pv; pred_pc = pc; pred_taken = pt;
    res_valid = rv; res_taken = rt;
    res = rv && (q.size() != 0);
    enq = pv && (q.size() < DEPTH);
    mis = 0;
    if (rv && q.size() == 0) m_uf = 1;
    m_uv = res;
    m_miss = 0;
    if (res) begin
      h = q.pop_front();
      m_pc = h.pc;
      m_tk = rt;
      mis = (h.pred != rt);
      m_miss = mis;
      if (m_tot != CMAX) m_tot++;
      if (mis) begin
        if (m_mc != CMAX) m_mc++;
        q.delete();
      end
    end
    if (enq && !mis) q.push_back('{pc, pt});
    @(posedge clk);
    #1;
    pred_valid = 0;
    res_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    #3;
    n_checks++;
    if ({upd_valid, upd_pc, upd_taken, mispredict, underflow} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 0", {upd_valid, upd_pc, upd_taken, mispredict, underflow});
    end
    n_checks++;
    if (pred_ready !== 1'b1 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ready got rdy=%b occ=%0d want 1/0", pred_ready, occupancy);
    end
    n_checks++;
    if (total_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", total_cnt, miss_cnt);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    cycle(1, 9'h005, 1, 0, 0);
    cycle(1, 9'h00A, 0, 0, 0);
    cycle(0, 9'h000, 0, 1, 1);
    n_checks++;
    if ({upd_valid, upd_pc, upd_taken, mispredict} !== {1'b1, 9'h005, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_upd got v=%b pc=%h t=%b m=%b want 1/005/1/0", upd_valid, upd_pc, upd_taken, mispredict);
    end
    n_checks++;
    if (occupancy !== 3'd1) begin
      n_fail++;
      $display("FAIL basic_occ got %0d want 1", occupancy);
    end
    cycle(0, 9'h000, 0, 1, 0);
    n_checks++;
    if ({upd_valid, upd_pc, mispredict} !== {1'b1, 9'h00A, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_upd2 got v=%b pc=%h m=%b want 1/00a/0", upd_valid, upd_pc, mispredict);
    end
    cycle(0, 9'h000, 0, 0, 0);
    n_checks++;
    if (upd_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_idle got v=%b occ=%0d want 0/0", upd_valid, occupancy);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) cycle(1, 9'(16 + i), i[0], 0, 0);
    n_checks++;
    if (pred_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL full_ready got rdy=%b occ=%0d want 0/4", pred_ready, occupancy);
    end
    cycle(1, 9'h1FF, 1, 0, 0);
    n_checks++;
    if (occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL full_ignore got occ=%0d want 4", occupancy);
    end
    // full plus correct resolve: enqueue still refused
    cycle(1, 9'h0AA, 1, 1, 0);
    n_checks++;
    if (occupancy !== 3'd3 || upd_pc !== 9'h010 || upd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop got occ=%0d pc=%h v=%b want 3/010/1", occupancy, upd_pc, upd_valid);
    end
    for (int i = 1; i < 4; i++) begin
      cycle(0, 9'h000, 0, 1, i[0]);
      n_checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 9'(16 + i) || mispredict !== 1'b0) begin
        n_fail++;
        $display("FAIL full_order%0d got v=%b pc=%h m=%b want 1/%h/0", i, upd_valid, upd_pc, mispredict, 9'(16 + i));
      end
    end
    n_checks++;
    if (occupancy !== 3'd0 || pred_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain got occ=%0d rdy=%b want 0/1", occupancy, pred_ready);
    end
  endtask

  task automatic test_flush();
    cycle(1, 9'h001, 0, 0, 0);
    cycle(1, 9'h002, 1, 0, 0);
    cycle(1, 9'h003, 1, 0, 0);
    cycle(1, 9'h004, 1, 1, 1);
    n_checks++;
    if ({upd_valid, mispredict, upd_pc, upd_taken} !== {1'b1, 1'b1, 9'h001, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_upd got v=%b m=%b pc=%h t=%b want 1/1/001/1", upd_valid, mispredict, upd_pc, upd_taken);
    end
    n_checks++;
    if (occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_occ got %0d want 0", occupancy);
    end
    cycle(1, 9'h005, 0, 0, 0);
    n_checks++;
    if (mispredict !== 1'b0 || upd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pulse got m=%b v=%b want 0/0", mispredict, upd_valid);
    end
    cycle(0, 9'h000, 0, 1, 0);
    n_checks++;
    if (upd_pc !== 9'h005 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_drop got pc=%h occ=%0d want 005/0", upd_pc, occupancy);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 9'h000, 0, 1, 1);
    n_checks++;
    if (upd_valid !== 1'b0 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL uflow_set got v=%b uf=%b want 0/1", upd_valid, underflow);
    end
    cycle(1, 9'h033, 1, 0, 0);
    cycle(0, 9'h000, 0, 1, 1);
    n_checks++;
    if (underflow !== 1'b1 || upd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL uflow_hold got uf=%b v=%b want 1/1", underflow, upd_valid);
    end
    apply_reset();
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_clr got %b want 0", underflow);
    end
  endtask

  task automatic test_stream();
    logic p;
    apply_reset();
    cycle(1, 9'h100, 1, 0, 0);
    cycle(1, 9'h101, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      p = 1'($urandom);
      cycle(1, 9'(258 + i), p, 1, q[0].pred);
      n_checks++;
      if (upd_valid !== 1'b1 || upd_pc !== 9'(256 + i) || mispredict !== 1'b0 || occupancy !== 3'd2) begin
        n_fail++;
        $display("FAIL stream%0d got v=%b pc=%h m=%b occ=%0d want 1/%h/0/2", i, upd_valid, upd_pc, mispredict, occupancy, 9'(256 + i));
      end
    end
    n_checks++;
    if (total_cnt !== cnt_exp(16'd20) || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stream_cnt got %0d/%0d want %0d/0", total_cnt, miss_cnt, cnt_exp(16'd20));
    end
  endtask

  task automatic test_random();
    logic rt;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      rt = 1'($urandom);
      if (q.size() != 0 && $urandom_range(3) != 0) rt = q[0].pred;
      cycle(1'($urandom_range(2) != 0), 9'($urandom), 1'($urandom),
            1'($urandom_range(1)), rt);
      n_checks++;
      if ({upd_valid, upd_pc, upd_taken, mispredict, underflow} !== {m_uv, m_pc, m_tk, m_miss, m_uf}
          || occupancy !== m_occ() || pred_ready !== (q.size() < DEPTH)
          || total_cnt !== cnt_exp(m_tot) || miss_cnt !== cnt_exp(m_mc)) begin
        n_fail++;
        $display("FAIL rand%0d got v=%b pc=%h t=%b m=%b uf=%b occ=%0d tot=%0d mc=%0d want %b/%h/%b/%b/%b/%0d/%0d/%0d",
                 i, upd_valid, upd_pc, upd_taken, mispredict, underflow, occupancy, total_cnt, miss_cnt,
                 m_uv, m_pc, m_tk, m_miss, m_uf, m_occ(), cnt_exp(m_tot), cnt_exp(m_mc));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1, 9'(64 + i), 1, 0, 0);
    cycle(0, 9'h000, 0, 1, 1);
    n_checks++;
    if (upd_valid !== 1'b1 || occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL areset_pre got v=%b occ=%0d want 1/3", upd_valid, occupancy);
    end
    #2 reset = 0;
    #1;
    n_checks++;
    if ({upd_valid, upd_pc, upd_taken, mispredict} !== 12'd0
        || occupancy !== 3'd0 || pred_ready !== 1'b1 || total_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_async got v=%b pc=%h occ=%0d rdy=%b tot=%0d want 0/000/0/1/0", upd_valid, upd_pc, occupancy, pred_ready, total_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1;
    cycle(1, 9'h077, 0, 0, 0);
    n_checks++;
    if (occupancy !== 3'd1) begin
      n_fail++;
      $display("FAIL areset_first got occ=%0d want 1", occupancy);
    end
    cycle(0, 9'h000, 0, 1, 0);
    n_checks++;
    if (upd_pc !== 9'h077 || upd_valid !== 1'b1 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_pop got pc=%h v=%b occ=%0d want 077/1/0", upd_pc, upd_valid, occupancy);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_underflow();
    test_stream();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_resolve_queue.md
Name: bht_resolve_queue

Overview:
- In-order in-flight branch tracker between the BHT prediction output and branch resolution in execute.
- Each prediction issued from fetch is stored with its PC as {pc, predicted bit}.
- When execute resolves the oldest branch, the block produces a registered update (pc, taken) that drives the BHT's pc/taken inputs, flags mispredictions and squashes younger entries.

Parameters:
- DEPTH, 4, number of in-flight entries; power of two, 2..16.
- PC_W, 9, width of the stored PC; matches the BHT pc port.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pred_valid  input  1  fetch issues a predicted branch this cycle.
- pred_pc  input  PC_W  PC of the issued branch.
- pred_taken  input  1  BHT prediction for pred_pc.
- pred_ready  output  1  queue can accept; equals !full.
- res_valid  input  1  execute resolves the oldest outstanding branch.
- res_taken  input  1  actual outcome.
- upd_valid  output  1  one-cycle pulse: BHT update this cycle.
- upd_pc  output  PC_W  PC to update (drives BHT pc).
- upd_taken  output  1  outcome to train (drives BHT taken).
- mispredict  output  1  one-cycle pulse, coincident with upd_valid, when the prediction was wrong.
- underflow  output  1  sticky error: res_valid seen while empty.
- occupancy  output  clog2(DEPTH)+1  current entry count.
- total_cnt  output  CNT_W  resolved branches.
- miss_cnt  output  CNT_W  mispredicted branches.

Behaviour:
- Storage: circular buffer, DEPTH entries of {pc, pred}.
  - Pointers wr_ptr and rd_ptr are clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
- Enqueue: when pred_valid && pred_ready at a rising edge, write {pred_pc, pred_taken} at wr_ptr and increment wr_ptr. pred_valid while full is ignored; no entry is written.
- Resolve: when res_valid && !empty at a rising edge:
  - pop the head entry;
  - next cycle: upd_valid=1, upd_pc=head.pc, upd_taken=res_taken, mispredict=(head.pred != res_taken).
  - Update latency is exactly 1 cycle after the resolve handshake.
- Misprediction flush: on a mispredicting resolve, set wr_ptr := rd_ptr+1, discarding all younger entries. A same-cycle enqueue is dropped (wrong-path fetch).
- Correct resolve plus simultaneous enqueue: both occur, and occupancy is unchanged.
- Full plus simultaneous correct resolve: pred_ready is still 0 (no bypass); only the pop occurs.
- Empty plus res_valid: no pop, no upd_valid; underflow is set to 1 and held until reset.
- Outputs are registered. upd_valid and mispredict pulse for exactly one cycle per resolve. Back-to-back resolves give back-to-back pulses.
- Counters: on each resolve, total_cnt increments by 1, and miss_cnt also increments on a mispredict. Both saturate at 2^CNT_W-1; no wrap.
- Reset (reset=0, asynchronous, any time including mid-operation):
  - pointers = 0, so empty;
  - upd_valid=0, upd_pc=0, upd_taken=0, mispredict=0, underflow=0, total_cnt=0, miss_cnt=0;
  - pred_ready=1 and occupancy=0 once reset is asserted.
  - Entry contents need not be cleared.
  - The first handshake is accepted at the first rising edge after deassertion.

Optional Feature:
- Macro BHT_RESOLVE_STATS_EN.
  - Defined: total_cnt and miss_cnt counters are implemented as above.
  - Undefined: counter registers are not built; total_cnt and miss_cnt are constant 0. All other behaviour is identical.

Test Plan:
- Reset, then enqueue pc=0x005/pred=1, 0x00A/pred=0; resolve taken=1 -> next cycle upd_valid=1, upd_pc=0x005, upd_taken=1, mispredict=0, occupancy=1.
- Enqueue 4 entries (DEPTH=4) -> pred_ready=0; a 5th pred_valid is ignored. Resolve all 4 with correct outcomes -> 4 consecutive upd pulses in FIFO order, occupancy=0.
- Enqueue pc 0x001 (pred 0), 0x002, 0x003; resolve taken=1 -> mispredict=1, upd_pc=0x001, occupancy=0. A same-cycle pred_valid with pc 0x004 is not stored.
- res_valid while empty -> no upd_valid; underflow=1 and stays 1 until reset=0.
- Streaming: simultaneous enqueue and correct resolve each cycle for 20 cycles across pointer wrap -> occupancy constant, PCs returned in order. With BHT_RESOLVE_STATS_EN: total_cnt=20, miss_cnt=0; without it, both 0.
- Assert reset mid-stream with 3 entries -> outputs are at their reset values before the next clock edge (asynchronous); after deassertion the queue is empty and pred_ready=1.
